cube_v3: RTL and testbench

CUBE_V3 -- requirements
Module: cube_v3

---
 rtl/cube_pkg.sv | 18 +
 rtl/cube_face_classify.sv | 125 ++++++++++++
 rtl/cube_v3.sv | 151 +++++++++++++++
 tb/tb_cube_v3.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// cube_pkg -- shared types for the cube_v3 pyramid-cube block.
//   mode_e  : landing rule applied to the top-face colour level.
//   state_e : colour FSM states (IDLE waits for a hop aimed at this cube,
//             ARMED waits for that hop to land).
package cube_pkg;

   typedef enum logic [1:0] {
      MODE_SAT    = 2'd0,
      MODE_WRAP   = 2'd1,
      MODE_REVERT = 2'd2
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_e;

endpackage

// File: rtl/cube_face_classify.sv
// cube_face_classify -- three-stage pixel classifier for one isometric cube.
// Decides whether pixel (x_cnt, y_cnt) lies on the top, left or right face of
// the cube described by the latched geometry. Latency is exactly 3 cycles and
// one pixel is accepted every cycle.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   x_cnt, y_cnt        pixel row / column
//   pix_valid           pixel qualifier
//   geo_x0, geo_y0      vertex 0 of the cube
//   geo_dx, geo_dy      half-diagonal of the top face
//   geo_len             side-face height
//   top_face, left_face, right_face   registered face flags (at most one set)
//   pix_valid_o         pix_valid delayed by 3 cycles
module cube_face_classify #(
   parameter int XW = 11,
   parameter int YW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [XW-1:0] x_cnt,
   input  logic [YW-1:0] y_cnt,
   input  logic          pix_valid,
   input  logic [XW-1:0] geo_x0,
   input  logic [YW-1:0] geo_y0,
   input  logic [XW-1:0] geo_dx,
   input  logic [YW-1:0] geo_dy,
   input  logic [XW-1:0] geo_len,
   output logic          top_face,
   output logic          left_face,
   output logic          right_face,
   output logic          pix_valid_o
);

   // Every product operand is widened to PW bits so no product or sum can
   // overflow, whatever the geometry.
   localparam int MW = (XW > YW) ? XW : YW;
   localparam int PW = 2 * (MW + 3);

   // Stage 1: offsets from vertex 0.
   logic                 v1_q;
   logic signed [XW:0]   dx_q;
   logic signed [YW:0]   dy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         v1_q <= 1'b0;
         dx_q <= '0;
         dy_q <= '0;
      end else begin
         v1_q <= pix_valid;
         dx_q <= $signed({1'b0, x_cnt}) - $signed({1'b0, geo_x0});
         dy_q <= $signed({1'b0, y_cnt}) - $signed({1'b0, geo_y0});
      end
   end

   // Stage 2: products.
   logic signed [PW-1:0] dx_w, dy_w, gdx_w, gdy_w, glen_w;
   logic signed [PW-1:0] dyo_w, a_w, rem_w;
   logic                 in_y_w;

   assign dx_w   = PW'(dx_q);
   assign dy_w   = PW'(dy_q);
   assign gdx_w  = $signed(PW'(geo_dx));
   assign gdy_w  = $signed(PW'(geo_dy));
   assign glen_w = $signed(PW'(geo_len));
   assign dyo_w  = dy_w - gdy_w;
   assign a_w    = dyo_w[PW-1] ? -dyo_w : dyo_w;   // |dy - DY|
   assign rem_w  = gdy_w - a_w;                     // DY - a
   assign in_y_w = !dy_w[PW-1] && (dy_w <= gdy_w + gdy_w);

   logic                 v2_q, in_y_q, left_q;
   logic signed [PW-1:0] p_tl_q, p_tr_q, p_a_q, p_dx_q, p_rem_q, p_len_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         v2_q    <= 1'b0;
         in_y_q  <= 1'b0;
         left_q  <= 1'b0;
         p_tl_q  <= '0;
         p_tr_q  <= '0;
         p_a_q   <= '0;
         p_dx_q  <= '0;
         p_rem_q <= '0;
         p_len_q <= '0;
      end else begin
         v2_q    <= v1_q;
         in_y_q  <= in_y_w;
         left_q  <= !dyo_w[PW-1];             // dy >= DY
         p_tl_q  <= (dx_w + gdx_w) * gdy_w;
         p_tr_q  <= (gdx_w - dx_w) * gdy_w;
         p_a_q   <= gdx_w * a_w;
         p_dx_q  <= dx_w * gdy_w;
         p_rem_q <= gdx_w * rem_w;
         p_len_q <= glen_w * gdy_w;
      end
   end

   // Stage 3: compares. The top test bounds dx*DY by +-DX*(DY-a) and the side
   // test starts strictly above that bound, so top and side never overlap.
   logic top_w, side_w;
   logic top_q, left_face_q, right_face_q, v3_q;

   assign top_w  = in_y_q && (p_tl_q >= p_a_q) && (p_tr_q >= p_a_q);
   assign side_w = in_y_q && (p_dx_q > p_rem_q) && (p_dx_q <= p_rem_q + p_len_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         v3_q         <= 1'b0;
         top_q        <= 1'b0;
         left_face_q  <= 1'b0;
         right_face_q <= 1'b0;
      end else begin
         v3_q         <= v2_q;
         top_q        <= v2_q && top_w;
         left_face_q  <= v2_q && side_w && left_q;
         right_face_q <= v2_q && side_w && !left_q;
      end
   end

   assign top_face    = top_q;
   assign left_face   = left_face_q;
   assign right_face  = right_face_q;
   assign pix_valid_o = v3_q;

endmodule

// File: rtl/cube_v3.sv
// cube_v3 -- one cube of the Q*bert pyramid: face classification of the
// current pixel plus the top-face colour level driven by hops landing here.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   x_cnt, y_cnt, pix_valid    pixel stream (x grows downward)
//   xy_offset {X0,Y0}, xydiag_demi {DX,DY}, xlength, geo_load
//                              geometry, latched only when geo_load=1
//   hop_start, cube_sel        a hop begins toward the one-hot target
//   done_move                  the hop landed
//   lvl_clear                  force level 0 / IDLE (highest priority)
//   top_face, left_face, right_face, pix_valid_o   classifier results
//   top_level, cube_done       registered colour level, level at top
//   dbg_state                  current colour FSM state
// Handshake: hop_start/done_move are single-cycle strobes sampled on every
// clk edge; there is no back-pressure, a strobe is acted on in the cycle it
// is high or lost.
module cube_v3
   import cube_pkg::*;
#(
   parameter int    N_CUBE   = 28,
   parameter int    CUBE_IDX = 0,
   parameter int    XW       = 11,
   parameter int    YW       = 10,
   parameter int    N_LEVELS = 2,
   parameter mode_e MODE     = MODE_SAT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [XW-1:0]                 x_cnt,
   input  logic [YW-1:0]                 y_cnt,
   input  logic                          pix_valid,
   input  logic [XW+YW-1:0]              xy_offset,
   input  logic [XW+YW-1:0]              xydiag_demi,
   input  logic [XW-1:0]                 xlength,
   input  logic                          geo_load,
   input  logic                          hop_start,
   input  logic [N_CUBE-1:0]             cube_sel,
   input  logic                          done_move,
   input  logic                          lvl_clear,
   output logic                          top_face,
   output logic                          left_face,
   output logic                          right_face,
   output logic                          pix_valid_o,
   output logic [$clog2(N_LEVELS)-1:0]   top_level,
   output logic                          cube_done,
   output state_e                        dbg_state
);

   localparam int                LW       = $clog2(N_LEVELS);
   localparam logic [LW-1:0]     LVL_TOP  = LW'(N_LEVELS - 1);
   localparam logic [N_CUBE-1:0] SEL_MASK = N_CUBE'(1) << CUBE_IDX;

   // Geometry is held between loads so a frame is never drawn with a mix of
   // old and new values.
   logic [XW-1:0] gx0_q, gdx_q, glen_q;
   logic [YW-1:0] gy0_q, gdy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         gx0_q  <= '0;
         gy0_q  <= '0;
         gdx_q  <= '0;
         gdy_q  <= '0;
         glen_q <= '0;
      end else if (geo_load) begin
         gx0_q  <= xy_offset[XW+YW-1:YW];
         gy0_q  <= xy_offset[YW-1:0];
         gdx_q  <= xydiag_demi[XW+YW-1:YW];
         gdy_q  <= xydiag_demi[YW-1:0];
         glen_q <= xlength;
      end
   end

   cube_face_classify #(
      .XW (XW),
      .YW (YW)
   ) u_classify (
      .clk         (clk),
      .reset       (reset),
      .x_cnt       (x_cnt),
      .y_cnt       (y_cnt),
      .pix_valid   (pix_valid),
      .geo_x0      (gx0_q),
      .geo_y0      (gy0_q),
      .geo_dx      (gdx_q),
      .geo_dy      (gdy_q),
      .geo_len     (glen_q),
      .top_face    (top_face),
      .left_face   (left_face),
      .right_face  (right_face),
      .pix_valid_o (pix_valid_o)
   );

   // Colour FSM.
   state_e        state_q, state_d;
   logic [LW-1:0] lvl_q, lvl_d, lvl_up;
   logic          sel;

   assign sel = |(cube_sel & SEL_MASK);

   // Level reached by a landing, according to the landing rule.
   always_comb begin
      lvl_up = lvl_q;
      case (MODE)
         MODE_WRAP:   lvl_up = (lvl_q == LVL_TOP) ? '0 : lvl_q + 1'b1;
         MODE_REVERT: lvl_up = (lvl_q == LVL_TOP) ? lvl_q - 1'b1 : lvl_q + 1'b1;
         default:     lvl_up = (lvl_q == LVL_TOP) ? lvl_q : lvl_q + 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      if (lvl_clear) begin
         state_d = IDLE;
         lvl_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               // A landing without a preceding hop toward us is ignored.
               if (hop_start && sel) state_d = ARMED;
            end
            ARMED: begin
               if (done_move) begin
                  // A new hop starting in the landing cycle re-arms at once.
                  lvl_d   = lvl_up;
                  state_d = (hop_start && sel) ? ARMED : IDLE;
               end else if (hop_start) begin
                  state_d = sel ? ARMED : IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         lvl_q   <= '0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
      end
   end

   assign top_level = lvl_q;
   assign cube_done = (lvl_q == LVL_TOP);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cube_v3.sv
module tb_cube_v3;
   import cube_pkg::*;

   localparam int XW = 11;
   localparam int YW = 10;
   localparam int NC = 28;

   // ---------------- clock / reset / DUT signals ----------------
   logic               clk;
   logic               reset;
   logic [XW-1:0]      x_cnt;
   logic [YW-1:0]      y_cnt;
   logic               pix_valid;
   logic [XW+YW-1:0]   xy_offset, xydiag_demi;
   logic [XW-1:0]      xlength;
   logic               geo_load, hop_start, done_move, lvl_clear;
   logic [NC-1:0]      cube_sel;

   logic [2:0]         top_f, left_f, right_f, pvo, done_f, st_b;
   logic               lvl_s;
   logic [1:0]         lvl_w, lvl_r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance 0: SAT, 2 levels, index 0. Instance 1: WRAP, 3 levels, index 0.
   // Instance 2: REVERT, 3 levels, index 3.
   cube_v3 #(.N_CUBE(NC), .CUBE_IDX(0), .XW(XW), .YW(YW), .N_LEVELS(2), .MODE(MODE_SAT)) u_sat (
      .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_valid(pix_valid),
      .xy_offset(xy_offset), .xydiag_demi(xydiag_demi), .xlength(xlength), .geo_load(geo_load),
      .hop_start(hop_start), .cube_sel(cube_sel), .done_move(done_move), .lvl_clear(lvl_clear),
      .top_face(top_f[0]), .left_face(left_f[0]), .right_face(right_f[0]), .pix_valid_o(pvo[0]),
      .top_level(lvl_s), .cube_done(done_f[0]), .dbg_state(st_b[0]));

   cube_v3 #(.N_CUBE(NC), .CUBE_IDX(0), .XW(XW), .YW(YW), .N_LEVELS(3), .MODE(MODE_WRAP)) u_wrap (
      .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_valid(pix_valid),
      .xy_offset(xy_offset), .xydiag_demi(xydiag_demi), .xlength(xlength), .geo_load(geo_load),
      .hop_start(hop_start), .cube_sel(cube_sel), .done_move(done_move), .lvl_clear(lvl_clear),
      .top_face(top_f[1]), .left_face(left_f[1]), .right_face(right_f[1]), .pix_valid_o(pvo[1]),
      .top_level(lvl_w), .cube_done(done_f[1]), .dbg_state(st_b[1]));

   cube_v3 #(.N_CUBE(NC), .CUBE_IDX(3), .XW(XW), .YW(YW), .N_LEVELS(3), .MODE(MODE_REVERT)) u_rev (
      .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_valid(pix_valid),
      .xy_offset(xy_offset), .xydiag_demi(xydiag_demi), .xlength(xlength), .geo_load(geo_load),
      .hop_start(hop_start), .cube_sel(cube_sel), .done_move(done_move), .lvl_clear(lvl_clear),
      .top_face(top_f[2]), .left_face(left_f[2]), .right_face(right_f[2]), .pix_valid_o(pvo[2]),
      .top_level(lvl_r), .cube_done(done_f[2]), .dbg_state(st_b[2]));

   // ---------------- reference model state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [3:0]  exp_q[$];          // {valid, top, left, right} per pixel slot
   int          gx0, gy0, gdx, gdy, glen;
   int          m_lvl[3];
   bit          m_arm[3];
   int          m_n[3]   = '{2, 3, 3};
   int          m_idx[3] = '{0, 0, 3};
   int          m_mode[3] = '{0, 1, 2};   // 0 saturate, 1 wrap, 2 revert

   // Face membership straight from the cube's defining inequalities.
   function automatic logic [3:0] classify(input int x, input int y, input int x0, input int y0,
                                           input int ddx, input int ddy, input int xl);
      longint dx, dy, a;
      bit in_y, t, s;
      dx   = x - x0;
      dy   = y - y0;
      a    = (dy >= ddy) ? dy - ddy : ddy - dy;
      in_y = (dy >= 0) && (dy <= 2 * ddy);
      t    = in_y && ((dx + ddx) * ddy >= ddx * a) && ((ddx - dx) * ddy >= ddx * a);
      s    = in_y && (dx * ddy > ddx * (ddy - a)) && (dx * ddy <= ddx * (ddy - a) + longint'(xl) * ddy);
      return {1'b1, t, s && (dy >= ddy), s && (dy < ddy)};
   endfunction

   function automatic int landed(input int k, input int lvl);
      int top;
      top = m_n[k] - 1;
      if (lvl < top) return lvl + 1;
      if (m_mode[k] == 0) return top;
      if (m_mode[k] == 1) return 0;
      return top - 1;
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, k, obs, exp);
      end
   endtask

   // ---------------- driver: one clock step with model update and checks ----------------
   task automatic tick();
      logic [3:0]  e;
      logic [31:0] obs_l[3];
      bit          sel;
      if (!reset) begin
         foreach (exp_q[i]) exp_q[i] = '0;
         exp_q.push_back('0);
         gx0 = 0; gy0 = 0; gdx = 0; gdy = 0; glen = 0;
         for (int k = 0; k < 3; k++) begin
            m_lvl[k] = 0;
            m_arm[k] = 1'b0;
         end
      end else begin
         exp_q.push_back(pix_valid ? classify(int'(x_cnt), int'(y_cnt), gx0, gy0, gdx, gdy, glen) : 4'b0);
         if (geo_load) begin
            gx0  = int'(xy_offset[XW+YW-1:YW]);
            gy0  = int'(xy_offset[YW-1:0]);
            gdx  = int'(xydiag_demi[XW+YW-1:YW]);
            gdy  = int'(xydiag_demi[YW-1:0]);
            glen = int'(xlength);
         end
         for (int k = 0; k < 3; k++) begin
            sel = cube_sel[m_idx[k]];
            if (lvl_clear) begin
               m_lvl[k] = 0;
               m_arm[k] = 1'b0;
            end else if (m_arm[k]) begin
               if (done_move) begin
                  m_lvl[k] = landed(k, m_lvl[k]);
                  m_arm[k] = hop_start && sel;
               end else if (hop_start) begin
                  m_arm[k] = sel;
               end
            end else if (hop_start && sel) begin
               m_arm[k] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            chk("pix_valid_o", k, 32'(pvo[k]),     32'(e[3]));
            chk("top_face",    k, 32'(top_f[k]),   32'(e[2]));
            chk("left_face",   k, 32'(left_f[k]),  32'(e[1]));
            chk("right_face",  k, 32'(right_f[k]), 32'(e[0]));
         end
      end
      obs_l[0] = 32'(lvl_s);
      obs_l[1] = 32'(lvl_w);
      obs_l[2] = 32'(lvl_r);
      for (int k = 0; k < 3; k++) begin
         chk("top_level", k, obs_l[k], 32'(m_lvl[k]));
         chk("cube_done", k, 32'(done_f[k]), 32'(m_lvl[k] == m_n[k] - 1));
         chk("state",     k, 32'(st_b[k]),   32'(m_arm[k]));
      end
   endtask

   task automatic load_geo(input int x0, input int y0, input int ddx, input int ddy, input int xl);
      logic [XW-1:0] xv, dxv, lv;
      logic [YW-1:0] yv, dyv;
      xv = XW'(x0); yv = YW'(y0); dxv = XW'(ddx); dyv = YW'(ddy); lv = XW'(xl);
      xy_offset   = {xv, yv};
      xydiag_demi = {dxv, dyv};
      xlength     = lv;
      geo_load    = 1'b1;
      pix_valid   = 1'b0;
      tick();
      geo_load    = 1'b0;
   endtask

   task automatic hop(input int idx);
      hop_start = 1'b1; cube_sel = '0; cube_sel[idx] = 1'b1;
      tick();
      hop_start = 1'b0; cube_sel = '0;
      tick();
      done_move = 1'b1;
      tick();
      done_move = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int         px[5]   = '{100, 130, 130, 200, 100};
   int         py[5]   = '{240, 260, 220, 240, 300};
   logic [2:0] pexp[5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000};
   int         wexp[4] = '{1, 2, 0, 1};

   initial begin
      int x0, y0, ddx, ddy, xl, xi, yi, idx;
      reset = 1'b0; x_cnt = '0; y_cnt = '0; pix_valid = 1'b0;
      xy_offset = '0; xydiag_demi = '0; xlength = '0; geo_load = 1'b0;
      hop_start = 1'b0; cube_sel = '0; done_move = 1'b0; lvl_clear = 1'b0;

      // Reset state.
      repeat (4) tick();
      chk("rst_top_level", 1, 32'(lvl_w), 32'd0);
      chk("rst_state",     1, 32'(st_b[1]), 32'd0);
      reset = 1'b1;
      tick();

      // Directed geometry and pixels, each checked exactly 3 cycles later.
      load_geo(100, 200, 20, 40, 50);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         x_cnt = XW'(px[i]); y_cnt = YW'(py[i]); pix_valid = 1'b1;
         tick();
         pix_valid = 1'b0;
         tick();
         chk("dir_early", i, 32'(pvo[0]), 32'd0);
         tick();
         chk("dir_faces", i, 32'({top_f[0], left_f[0], right_f[0]}), 32'(pexp[i]));
         chk("dir_valid", i, 32'(pvo[0]), 32'd1);
      end

      // Wrap with three levels: 1, 2, 0, 1.
      for (int i = 0; i < 4; i++) begin
         hop(0);
         chk("wrap_lvl",  i, 32'(lvl_w), 32'(wexp[i]));
         chk("wrap_done", i, 32'(done_f[1]), 32'(wexp[i] == 2));
      end

      // Landing while IDLE is ignored.
      done_move = 1'b1; tick(); done_move = 1'b0;
      chk("idle_land", 1, 32'(lvl_w), 32'd1);

      // Revert: up to the top, then one landing steps back.
      hop(3); hop(3);
      chk("rev_top",  2, 32'(lvl_r), 32'd2);
      chk("rev_done", 2, 32'(done_f[2]), 32'd1);
      hop(3);
      chk("rev_back", 2, 32'(lvl_r), 32'd1);

      // lvl_clear beats a simultaneous landing.
      hop_start = 1'b1; cube_sel = '0; cube_sel[0] = 1'b1; tick();
      hop_start = 1'b0; cube_sel = '0; tick();
      chk("armed", 1, 32'(st_b[1]), 32'd1);
      lvl_clear = 1'b1; done_move = 1'b1; tick();
      lvl_clear = 1'b0; done_move = 1'b0;
      chk("clr_lvl",   1, 32'(lvl_w), 32'd0);
      chk("clr_state", 1, 32'(st_b[1]), 32'd0);

      // Hop retargeted elsewhere disarms; hop + land together re-arms.
      hop_start = 1'b1; cube_sel = '0; cube_sel[0] = 1'b1; tick();
      cube_sel = '0; cube_sel[5] = 1'b1; tick();
      chk("retarget", 1, 32'(st_b[1]), 32'd0);
      cube_sel = '0; cube_sel[0] = 1'b1; tick();
      done_move = 1'b1; tick();
      chk("hop_land_lvl",   1, 32'(lvl_w), 32'd1);
      chk("hop_land_state", 1, 32'(st_b[1]), 32'd1);
      hop_start = 1'b0; cube_sel = '0; tick();
      done_move = 1'b0;
      chk("second_land", 1, 32'(lvl_w), 32'd2);

      // Reset while ARMED, then a landing: level stays 0.
      hop_start = 1'b1; cube_sel = '0; cube_sel[0] = 1'b1; tick();
      hop_start = 1'b0; cube_sel = '0;
      reset = 1'b0; tick();
      reset = 1'b1; done_move = 1'b1; tick();
      done_move = 1'b0;
      chk("rst_armed_lvl",   1, 32'(lvl_w), 32'd0);
      chk("rst_armed_state", 1, 32'(st_b[1]), 32'd0);

      // Randomized phase.
      for (int n = 0; n < 900; n++) begin
         if (n % 100 == 0) begin
            if ($urandom_range(0, 4) == 0) begin
               x0 = $urandom_range(0, 2047); y0 = $urandom_range(0, 1023);
               ddx = $urandom_range(0, 2047); ddy = $urandom_range(0, 1023); xl = $urandom_range(0, 2047);
            end else begin
               x0 = $urandom_range(0, 1500); y0 = $urandom_range(0, 700);
               ddx = $urandom_range(0, 300); ddy = $urandom_range(0, 150); xl = $urandom_range(0, 300);
            end
            load_geo(x0, y0, ddx, ddy, xl);
            continue;
         end
         // Geometry inputs wander without geo_load; latched values must hold.
         xy_offset   = (XW+YW)'($urandom);
         xydiag_demi = (XW+YW)'($urandom);
         xlength     = XW'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            xi = $urandom_range(0, 2047); yi = $urandom_range(0, 1023);
         end else begin
            xi = gx0 + int'($urandom_range(0, gdx + glen + 30)) - 15;
            yi = gy0 + int'($urandom_range(0, 2 * gdy + 20)) - 10;
         end
         if (xi < 0) xi = 0;
         if (xi > 2047) xi = 2047;
         if (yi < 0) yi = 0;
         if (yi > 1023) yi = 1023;
         x_cnt = XW'(xi); y_cnt = YW'(yi);
         pix_valid = ($urandom_range(0, 4) != 0);
         case ($urandom_range(0, 3))
            0: idx = 0;
            1: idx = 3;
            2: idx = 5;
            default: idx = $urandom_range(0, NC - 1);
         endcase
         cube_sel = '0; cube_sel[idx] = 1'b1;
         hop_start = ($urandom_range(0, 3) == 0);
         done_move = ($urandom_range(0, 2) == 0);
         lvl_clear = ($urandom_range(0, 40) == 0);
         reset     = ($urandom_range(0, 250) != 0);
         tick();
      end

      reset = 1'b1; pix_valid = 1'b0; hop_start = 1'b0; done_move = 1'b0; lvl_clear = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
